// File: rtl/lcd_sync_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_sync_pkg : shared state encoding and 800x480 panel timing defaults   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lcd_sync_pkg;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam int C_DEF_H_ACTIVE = 800;
    localparam int C_DEF_H_FP     = 40;
    localparam int C_DEF_H_SYNC   = 48;
    localparam int C_DEF_H_BP     = 40;
    localparam int C_DEF_V_ACTIVE = 480;
    localparam int C_DEF_V_FP     = 13;
    localparam int C_DEF_V_SYNC   = 3;
    localparam int C_DEF_V_BP     = 29;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timing_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_timing_counter : free-running h/v counters with region decode        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lcd_timing_counter
    import lcd_sync_pkg::*;
#(
    parameter int H_ACTIVE = C_DEF_H_ACTIVE,
    parameter int H_FP     = C_DEF_H_FP,
    parameter int H_SYNC   = C_DEF_H_SYNC,
    parameter int H_BP     = C_DEF_H_BP,
    parameter int V_ACTIVE = C_DEF_V_ACTIVE,
    parameter int V_FP     = C_DEF_V_FP,
    parameter int V_SYNC   = C_DEF_V_SYNC,
    parameter int V_BP     = C_DEF_V_BP
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_active,
    output logic o_first,
    output logic o_hs_on,
    output logic o_vs_on
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    // One spare bit of headroom so the sync-end bound fits even with a zero back porch
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == HW'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_hs_on  = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vs_on  = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule
`default_nettype wire

// File: rtl/lcd_stream_sync_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_stream_sync_generator : Avalon-ST pixel stream to RGB888 panel pins  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lcd_stream_sync_generator
    import lcd_sync_pkg::*;
#(
    parameter int   H_ACTIVE  = C_DEF_H_ACTIVE,
    parameter int   H_FP      = C_DEF_H_FP,
    parameter int   H_SYNC    = C_DEF_H_SYNC,
    parameter int   H_BP      = C_DEF_H_BP,
    parameter int   V_ACTIVE  = C_DEF_V_ACTIVE,
    parameter int   V_FP      = C_DEF_V_FP,
    parameter int   V_SYNC    = C_DEF_V_SYNC,
    parameter int   V_BP      = C_DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic        underflow,
    output logic        sync_error
);

    logic   w_active, w_first, w_hs_on, w_vs_on;
    logic   w_show, w_uf, w_se;
    state_t w_next;
    state_t r_state;
    logic [23:0] r_rgb;
    logic   r_hsync, r_vsync, r_de, r_uf, r_se;
    logic   w_unused;

    assign w_unused = ^{in_data[31:24], in_endofpacket, in_empty};

    lcd_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk      (clk),
        .reset_n  (reset_n),
        .o_active (w_active),
        .o_first  (w_first),
        .o_hs_on  (w_hs_on),
        .o_vs_on  (w_vs_on)
    );

    // A misaligned SOP is never accepted so it can start the next frame cleanly
    always_comb begin
        in_ready = 1'b0;
        w_show   = 1'b0;
        w_uf     = 1'b0;
        w_se     = 1'b0;
        w_next   = r_state;
        case (r_state)
            ST_SEARCH: begin
                in_ready = !(in_valid && in_startofpacket && !w_first);
                if (w_first && in_valid && in_startofpacket) begin
                    w_show = 1'b1;
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_active) begin
                    if (!in_valid) begin
                        in_ready = 1'b1;
                        w_uf     = 1'b1;
                        w_next   = ST_SEARCH;
                    end else if (in_startofpacket ^ w_first) begin
                        w_se     = 1'b1;
                        w_next   = ST_SEARCH;
                    end else begin
                        in_ready = 1'b1;
                        w_show   = 1'b1;
                    end
                end
            end
            default: w_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SEARCH;
            r_rgb   <= '0;
            r_de    <= 1'b0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_uf    <= 1'b0;
            r_se    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rgb   <= w_show ? in_data[23:0] : 24'h0;
            r_de    <= w_active;
            r_hsync <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
            r_uf    <= w_uf;
            r_se    <= w_se;
        end
    end

    assign lcd_r      = r_rgb[23:16];
    assign lcd_g      = r_rgb[15:8];
    assign lcd_b      = r_rgb[7:0];
    assign lcd_de     = r_de;
    assign lcd_hsync  = r_hsync;
    assign lcd_vsync  = r_vsync;
    assign underflow  = r_uf;
    assign sync_error = r_se;

endmodule
`default_nettype wire

// File: tb/tb_lcd_stream_sync_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_stream_sync_generator : scoreboard bench with frame-level model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lcd_stream_sync_generator;

    localparam int   HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int   VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FT = HT * VT;
    localparam int   NPIX = HA * VA;
    localparam logic HPOL = 1'b0, VPOL = 1'b0;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        uf;
        logic        se;
    } exp_t;

    typedef struct {
        bit          v;
        bit          sop;
        logic [31:0] d;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [1:0]  in_empty = '0;
    logic [7:0]  lcd_r, lcd_g, lcd_b;
    logic        lcd_hsync, lcd_vsync, lcd_de, underflow, sync_error;

    exp_t  expq[$];
    int    tq[$];
    stim_t stim[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    t = 0;
    bit    aligned = 1'b0;
    int    fid = 0;

    always #5 clk = ~clk;

    lcd_stream_sync_generator #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_empty         (in_empty),
        .lcd_r            (lcd_r),
        .lcd_g            (lcd_g),
        .lcd_b            (lcd_b),
        .lcd_hsync        (lcd_hsync),
        .lcd_vsync        (lcd_vsync),
        .lcd_de           (lcd_de),
        .underflow        (underflow),
        .sync_error       (sync_error)
    );

    function automatic exp_t pins();
        exp_t g;
        g = {lcd_r, lcd_g, lcd_b, lcd_de, lcd_hsync, lcd_vsync, underflow, sync_error};
        return g;
    endfunction

    // Frame-level reference: position comes from the cycle index, alignment is one flag
    task automatic model(input bit v, input bit sop, input logic [31:0] d,
                         output bit rdy, output exp_t e);
        int  h, ln;
        bit  act, fst;
        h   = t % HT;
        ln  = (t / HT) % VT;
        act = (h < HA) && (ln < VA);
        fst = (t % FT) == 0;
        e    = '0;
        e.de = act;
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
        e.vs = (ln >= VA + VF && ln < VA + VF + VS) ? VPOL : !VPOL;
        if (!aligned) begin
            rdy = !(v && sop && !fst);
            if (fst && v && sop) begin
                aligned = 1'b1;
                e.rgb   = d[23:0];
            end
        end else if (!act) begin
            rdy = 1'b0;
        end else if (!v) begin
            rdy     = 1'b1;
            e.uf    = 1'b1;
            aligned = 1'b0;
        end else if (sop != fst) begin
            rdy     = 1'b0;
            e.se    = 1'b1;
            aligned = 1'b0;
        end else begin
            rdy   = 1'b1;
            e.rgb = d[23:0];
        end
    endtask

    task automatic push_frame(input int n, input bit with_sop, input int gap_at);
        stim_t it;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                it = '{1'b0, 1'b0, 32'h0};
                stim.push_back(it);
            end
            it.v   = 1'b1;
            it.sop = with_sop && (i == 0);
            it.d   = {8'($urandom), 8'($urandom), 8'(fid), 8'(i)};
            stim.push_back(it);
        end
        fid++;
    endtask

    task automatic step();
        stim_t it;
        bit    rdy_m;
        exp_t  e;
        @(negedge clk);
        if (stim.size() > 0) it = stim[0];
        else it = '{1'b0, 1'b0, 32'h0};
        in_valid         = it.v;
        in_startofpacket = it.sop;
        in_data          = it.d;
        in_endofpacket   = 1'($urandom);
        in_empty         = 2'($urandom);
        #1;
        model(it.v, it.sop, it.d, rdy_m, e);
        n_cmp++;
        if (in_ready !== rdy_m) begin
            n_err++;
            $display("FAIL in_ready t=%0d got=%b exp=%b", t, in_ready, rdy_m);
        end
        expq.push_back(e);
        tq.push_back(t);
        if (stim.size() > 0 && in_ready) void'(stim.pop_front());
        t++;
    endtask

    task automatic run_stim(input int budget);
        int k = 0;
        while (stim.size() > 0 && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (stim.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout left=%0d required=0", stim.size());
            stim.delete();
        end
        repeat (FT) step();
    endtask

    task automatic check_reset(input string tag);
        exp_t r;
        r = '0;
        r.hs = !HPOL;
        r.vs = !VPOL;
        n_cmp++;
        if (pins() !== r) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, pins(), r);
        end
    endtask

    // Monitor: one registered pin snapshot per clock, checked against the scoreboard
    initial begin
        exp_t e;
        int   te;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && expq.size() > 0) begin
                e  = expq.pop_front();
                te = tq.pop_front();
                n_cmp++;
                if (pins() !== e) begin
                    n_err++;
                    $display("FAIL pins t=%0d got=%h exp=%h", te, pins(), e);
                end
            end
        end
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_values");
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        #1 reset_n = 1'b1;

        // idle stream
        repeat (100) step();

        // continuous frames, streaming begins mid-frame
        repeat (4) push_frame(NPIX, 1'b1, -1);
        run_stim(2000);

        // valid dropped at pixel 5
        push_frame(NPIX, 1'b1, 5);
        repeat (2) push_frame(NPIX, 1'b1, -1);
        run_stim(2000);

        // early SOP at pixel 7
        push_frame(7, 1'b1, -1);
        repeat (2) push_frame(NPIX, 1'b1, -1);
        run_stim(2000);

        // frame whose first pixel lacks SOP
        push_frame(NPIX, 1'b0, -1);
        repeat (2) push_frame(NPIX, 1'b1, -1);
        run_stim(2000);

        // randomized mix of good, short, SOP-less and gappy frames
        for (int i = 0; i < 25; i++) begin
            push_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NPIX)) : NPIX,
                       $urandom_range(0, 9) != 0,
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NPIX - 1)) : -1);
        end
        run_stim(10000);

        // reset in the middle of line 1 of a running frame
        repeat (3) push_frame(NPIX, 1'b1, -1);
        k = 0;
        do begin
            step();
            k++;
        end while (!(aligned && ((t - 1) % FT) == HT + 2) && k < 1000);
        n_cmp++;
        if (!aligned) begin
            n_err++;
            $display("FAIL reach_line1 aligned=%b required=1", aligned);
        end
        #1 reset_n = 1'b0;
        #1;
        check_reset("midframe_reset");
        expq.delete();
        tq.delete();
        stim.delete();
        in_valid = 1'b0;
        in_startofpacket = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        t = 0;
        aligned = 1'b0;
        repeat (2) push_frame(NPIX, 1'b1, -1);
        run_stim(2000);

        @(posedge clk);
        #2;
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left got=%0d exp=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
